// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencing stage: loadable program memory feeding the CPU.
// Optional FETCH_LOOP_EN wraps the program at its end while loop is high.
module instr_fetch_unit #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS = 5,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   loop,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic [PC_BITS:0]       prog_len,
  output logic                   load_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** PC_BITS;
  localparam logic [PC_BITS:0] ONE = (PC_BITS+1)'(1);
  localparam logic [PC_BITS-1:0] PC_ONE = PC_BITS'(1);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  state_t                 state, state_d;
  logic [PC_BITS-1:0]     pc_d;
  logic [PC_BITS-1:0]     wr_ptr, wr_ptr_d;
  logic [PC_BITS:0]       len_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   valid_d;
  logic                   done_d;
  logic                   ovf_d;
  logic                   we;
  logic                   full;
  logic                   last;

  assign full = prog_len[PC_BITS];
  assign last = ({1'b0, pc} == (prog_len - ONE));
  assign load_ready = (state == IDLE) && !full;
  assign busy = (state == RUN);

`ifndef FETCH_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop;
`endif

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    wr_ptr_d = wr_ptr;
    len_d    = prog_len;
    instr_d  = NOP_WORD;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    ovf_d    = overflow;
    we       = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          wr_ptr_d = '0;
          len_d    = '0;
          ovf_d    = 1'b0;
        end else if (start && (prog_len != '0)) begin
          state_d = RUN;
          pc_d    = '0;
        end else if (load_en) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr + PC_ONE;
            len_d    = prog_len + ONE;
          end
        end
      end
      RUN: begin
        if (halt) begin
          state_d = IDLE;
          pc_d    = '0;
        end else if (!stall) begin
          instr_d = mem[pc];
          valid_d = 1'b1;
          if (last) begin
`ifdef FETCH_LOOP_EN
            if (loop) pc_d = '0;
            else state_d = FIN;
`else
            state_d = FIN;
`endif
          end else begin
            pc_d = pc + PC_ONE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        pc_d    = '0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      wr_ptr      <= '0;
      prog_len    <= '0;
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      wr_ptr      <= wr_ptr_d;
      prog_len    <= len_d;
      instruction <= instr_d;
      instr_valid <= valid_d;
      done        <= done_d;
      overflow    <= ovf_d;
    end
  end

  // Program words are deliberately kept across reset and clear.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr] <= load_data;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-sequencing stage that sits directly upstream of the CPU datapath and drives its 20-bit `instruction` input. It holds a small program memory filled over a sequential load port, then issues one instruction per cycle from address 0 up to the loaded length. A stall input inserts NOP words, and a halt input aborts the run. Output is registered, so the CPU sees a clean, glitch-free instruction word every cycle.

## Interface
- `INSTR_WIDTH`, 20, instruction word width
- `PC_BITS`, 5, program memory address width (2^PC_BITS = 32 entries)
- `NOP_WORD`, 20'h00000, word driven whenever no instruction is issued
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `load_en` in 1: write `load_data` into program memory at the write pointer
- `load_data` in INSTR_WIDTH: instruction word to store
- `clear` in 1: discard the loaded program (resets write pointer and length)
- `start` in 1: begin issuing from address 0
- `stall` in 1: hold PC and issue NOP this cycle
- `halt` in 1: abort the run
- `loop` in 1: wrap at end of program (effective only with `FETCH_LOOP_EN`)
- `instruction` out INSTR_WIDTH: registered word to CPU
- `instr_valid` out 1: `instruction` is a real program word
- `pc` out PC_BITS: address of the next word to issue
- `prog_len` out PC_BITS+1: number of words loaded (0..32)
- `load_ready` out 1: IDLE and `prog_len` < 32
- `busy` out 1: state is RUN
- `done` out 1: one-cycle pulse at program end
- `overflow` out 1: sticky; a load was attempted while memory was full

## Operation
- **States:** IDLE, RUN, DONE. Reset puts the block in IDLE.
- **Reset values:** `pc`=0, write pointer=0, `prog_len`=0, `instruction`=NOP_WORD, `instr_valid`=0, `done`=0, `overflow`=0. Memory contents are not reset.
- **IDLE priority:** `clear` > `start` > `load_en`.
  - `clear`: write pointer and `prog_len` go to 0, and `overflow` is cleared.
  - `start` with `prog_len`>0: go to RUN with `pc`=0. Any simultaneous load is ignored. `start` with `prog_len`=0 is ignored.
  - `load_en` with `prog_len`<32: mem[wr_ptr]←`load_data`, then wr_ptr and `prog_len` increment.
  - `load_en` with `prog_len`=32: the write is dropped and `overflow` is set.
- **RUN, priority `halt` > `stall` > issue:**
  - `halt`: `instruction`←NOP_WORD, `instr_valid`←0, go to IDLE, `pc`←0.
  - `stall`: `instruction`←NOP_WORD, `instr_valid`←0, `pc` held.
  - issue: `instruction`←mem[pc], `instr_valid`←1.
    - If `pc` = `prog_len`−1: go to DONE (or wrap, see Configuration).
    - Otherwise `pc`←`pc`+1.
- **DONE:** `done`=1 and `instruction`=NOP_WORD for exactly one cycle, then IDLE with `pc`=0.
- `load_en`, `clear`, and `start` are ignored outside IDLE.
- PC arithmetic is unsigned, modulo 2^PC_BITS. The end-of-program compare uses `prog_len`−1 at PC_BITS+1 width.

## Timing
- `start` sampled at edge E0 puts the block in RUN after E0. mem[0] appears on `instruction` after E1, so there is 1 cycle from start to first word.
- With no stalls, N words take N consecutive cycles with `instr_valid`=1. `done` pulses on the cycle after the last word.
- Stall takes effect at the next edge, and issue resumes with the same `pc`.
- `halt` takes effect at the next edge. No word is issued on that edge.
- Memory read is synchronous to the output register, so no combinational path exists from the inputs to `instruction`.
- `rst` mid-RUN returns all state to reset values at the next edge. The loaded program words survive, but `prog_len`=0.

## Configuration
- `FETCH_LOOP_EN` defined: in RUN, issuing at `pc`=`prog_len`−1 with `loop`=1 sets `pc`←0 and stays in RUN with no `done` pulse. `halt` is the only exit.
- `FETCH_LOOP_EN` undefined: the `loop` port exists but is ignored, and every run ends in DONE.

## Test plan
- Load 3 words (0x12345, 0xABCDE, 0x0F0F0), then pulse start: `instruction` shows 0x12345, 0xABCDE, 0x0F0F0 with `instr_valid`=1 on 3 consecutive cycles, then `done`=1 for 1 cycle, then IDLE and `pc`=0.
- Same program with `stall`=1 on the 2nd issue cycle: sequence 0x12345, NOP (valid=0), 0xABCDE, 0x0F0F0.
- Load 32 words, then a 33rd: `overflow`=1, `load_ready`=0, `prog_len`=32, and mem[31] is unchanged.
- `halt` on the 2nd issue cycle: `instruction`=NOP_WORD, `busy`=0 next cycle, no `done` pulse. A later `start` reissues from 0x12345.
- `start` with `prog_len`=0: stays IDLE, `instr_valid` stays 0. `clear` together with `load_en`: `prog_len`=0.
- `FETCH_LOOP_EN` defined, `loop`=1, 2 words: output alternates word0, word1, word0, … until `halt`, and `done` never asserts.
